// File: rtl/kp_gaussian_mac_pkg.sv
// Shared constants for the 3x3 Gaussian MAC: kernel weights, normalisation
// shift, rounding constant and the derived intermediate widths.
package kp_pkg;

   // Kernel [1 2 1; 2 4 2; 1 2 1] is separable: the centre tap of each 1-D pass weighs 2.
   localparam int KP_WEIGHT_EDGE  = 1;
   localparam int KP_WEIGHT_MID   = 2;
   localparam int KP_MID_SHIFT    = 1;
   localparam int KP_NORM_SHIFT   = 4;
   localparam int KP_ROUND_CONST  = 8;

   function automatic int kp_row_w(input int dw);
      return dw + 2;
   endfunction

   function automatic int kp_total_w(input int dw);
      return dw + 4;
   endfunction

endpackage

// File: rtl/kp_gaussian_mac_row.sv
// Stage-1 row weighting: registered L + 2*C + R of one packed window row.
module kp_gauss_row
   import kp_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                              i_clk,
   input  logic [3*DATA_WIDTH-1:0]           i_row,
   output logic [kp_row_w(DATA_WIDTH)-1:0]   o_sum
);

   localparam int RW = kp_row_w(DATA_WIDTH);

   logic [RW-1:0] l_ext;
   logic [RW-1:0] c_ext;
   logic [RW-1:0] r_ext;

   assign l_ext = RW'(i_row[2*DATA_WIDTH +: DATA_WIDTH]);
   assign c_ext = RW'(i_row[DATA_WIDTH +: DATA_WIDTH]);
   assign r_ext = RW'(i_row[0 +: DATA_WIDTH]);

   always_ff @(posedge i_clk) begin
      o_sum <= l_ext + (c_ext << KP_MID_SHIFT) + r_ext;
   end

endmodule

// File: rtl/kp_gaussian_mac.sv
// Pipelined 3x3 Gaussian filter with frame/line markers.
// Optional macro KP_GAUSS_ROUND_EN selects round-half-up normalisation.
module kp_gaussian_mac
   import kp_pkg::*;
#(
   parameter int LINE_LENGTH = 640,
   parameter int LINE_COUNT  = 480,
   parameter int DATA_WIDTH  = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rstn,
   input  logic [3*DATA_WIDTH-1:0] i_r0_data,
   input  logic [3*DATA_WIDTH-1:0] i_r1_data,
   input  logic [3*DATA_WIDTH-1:0] i_r2_data,
   input  logic                    i_valid,
   output logic [DATA_WIDTH-1:0]   o_data,
   output logic                    o_valid,
   output logic                    o_sof,
   output logic                    o_eol,
   output logic                    o_eof
);

   localparam int RW = kp_row_w(DATA_WIDTH);
   localparam int TW = kp_total_w(DATA_WIDTH);
   localparam int CW = $clog2(LINE_LENGTH) + 1;
   localparam int LW = $clog2(LINE_COUNT) + 1;

`ifdef KP_GAUSS_ROUND_EN
   function automatic logic [DATA_WIDTH-1:0] kp_normalise(input logic [TW-1:0] t);
      logic [TW-1:0] t_rnd;
      t_rnd = t + TW'(KP_ROUND_CONST);
      return t_rnd[KP_NORM_SHIFT +: DATA_WIDTH];
   endfunction
`else
   function automatic logic [DATA_WIDTH-1:0] kp_normalise(input logic [TW-1:0] t);
      return t[KP_NORM_SHIFT +: DATA_WIDTH];
   endfunction
`endif

   logic [RW-1:0] s0_p0;
   logic [RW-1:0] s1_p0;
   logic [RW-1:0] s2_p0;
   logic          vld_p0;
   logic [TW-1:0] t_p1;
   logic          vld_p1;
   logic          vld_p2;
   logic [CW-1:0] col;
   logic [LW-1:0] row;
   logic          last_col;
   logic          last_row;

   // Stage 1: horizontal weighting of each row
   kp_gauss_row #(.DATA_WIDTH(DATA_WIDTH)) u_row0 (.i_clk(i_clk), .i_row(i_r0_data), .o_sum(s0_p0));
   kp_gauss_row #(.DATA_WIDTH(DATA_WIDTH)) u_row1 (.i_clk(i_clk), .i_row(i_r1_data), .o_sum(s1_p0));
   kp_gauss_row #(.DATA_WIDTH(DATA_WIDTH)) u_row2 (.i_clk(i_clk), .i_row(i_r2_data), .o_sum(s2_p0));

   // Stage 2: vertical weighting of the row sums
   always_ff @(posedge i_clk) begin
      t_p1 <= TW'(s0_p0) + (TW'(s1_p0) << KP_MID_SHIFT) + TW'(s2_p0);
   end

   assign last_col = (col == CW'(LINE_LENGTH - 1));
   assign last_row = (row == LW'(LINE_COUNT - 1));

   // Stage 3: normalise, decode markers for the pixel being emitted, advance counters
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         o_data <= '0;
         o_sof  <= 1'b0;
         o_eol  <= 1'b0;
         o_eof  <= 1'b0;
         col    <= '0;
         row    <= '0;
      end else begin
         vld_p0 <= i_valid;
         vld_p1 <= vld_p0;
         vld_p2 <= vld_p1;
         o_data <= kp_normalise(t_p1);
         o_sof  <= vld_p1 && (col == '0) && (row == '0);
         o_eol  <= vld_p1 && last_col;
         o_eof  <= vld_p1 && last_col && last_row;
         if (vld_p1) begin
            if (last_col) begin
               col <= '0;
               row <= last_row ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   assign o_valid = vld_p2;

endmodule

// File: tb/tb_kp_gaussian_mac.sv
// Directed self-checking bench for kp_gaussian_mac (small 4x2 frame geometry).
module tb_kp_gaussian_mac;

   logic        clk;
   logic        rstn;
   logic [23:0] r0, r1, r2;
   logic        valid;
   logic [7:0]  o_data;
   logic        o_valid, o_sof, o_eol, o_eof;

   int n_cmp;
   int n_fail;

   kp_gaussian_mac #(.LINE_LENGTH(4), .LINE_COUNT(2), .DATA_WIDTH(8)) dut (
      .i_clk(clk), .i_rstn(rstn),
      .i_r0_data(r0), .i_r1_data(r1), .i_r2_data(r2), .i_valid(valid),
      .o_data(o_data), .o_valid(o_valid), .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_win(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c, input logic v);
      r0 = a;
      r1 = b;
      r2 = c;
      valid = v;
   endtask

   task automatic do_reset;
      rstn = 1'b0;
      set_win(24'h0, 24'h0, 24'h0, 1'b0);
      tick();
      rstn = 1'b1;
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      set_win(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 1'b1);
      tick();
      tick();
      tick();
      n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
      n_cmp++; if (o_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", o_data); end
      n_cmp++; if (o_sof !== 1'b0) begin n_fail++; $display("FAIL reset_sof got=%b exp=0", o_sof); end
      n_cmp++; if (o_eol !== 1'b0) begin n_fail++; $display("FAIL reset_eol got=%b exp=0", o_eol); end
      n_cmp++; if (o_eof !== 1'b0) begin n_fail++; $display("FAIL reset_eof got=%b exp=0", o_eof); end
      rstn = 1'b1;
   endtask

   // Five back-to-back all-0xFF windows; output k corresponds to input driven 3 ticks earlier.
   task automatic test_back_to_back;
      int  n;
      logic ev;
      n = 0;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         if (c < 5) set_win(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 1'b1);
         else       set_win(24'h0, 24'h0, 24'h0, 1'b0);
         tick();
         ev = (c >= 2) && (c < 7);
         n_cmp++; if (o_valid !== ev) begin n_fail++; $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, o_valid, ev); end
         if (ev) begin
            n++;
            n_cmp++; if (o_data !== 8'hFF) begin n_fail++; $display("FAIL b2b_data n=%0d got=%h exp=ff", n, o_data); end
            n_cmp++; if (o_sof !== (n == 1)) begin n_fail++; $display("FAIL b2b_sof n=%0d got=%b", n, o_sof); end
            n_cmp++; if (o_eol !== (n == 4)) begin n_fail++; $display("FAIL b2b_eol n=%0d got=%b", n, o_eol); end
            n_cmp++; if (o_eof !== 1'b0) begin n_fail++; $display("FAIL b2b_eof n=%0d got=%b exp=0", n, o_eof); end
         end
      end
   endtask

   task automatic test_kernel_patterns;
      logic [23:0] w0 [7];
      logic [23:0] w1 [7];
      logic [23:0] w2 [7];
      logic [7:0]  ex [7];
      w0[0] = 24'h000000; w1[0] = 24'h008000; w2[0] = 24'h000000; ex[0] = 8'h20;
      w0[1] = 24'h000000; w1[1] = 24'h000100; w2[1] = 24'h000000; ex[1] = 8'h00;
      w0[2] = 24'h010101; w1[2] = 24'h010901; w2[2] = 24'h010101; ex[2] = 8'h03;
      w0[3] = 24'h180000; w1[3] = 24'h000000; w2[3] = 24'h000000;
      w0[4] = 24'h001000; w1[4] = 24'h000020; w2[4] = 24'h300000; ex[4] = 8'h09;
      w0[5] = 24'hFFFFFF; w1[5] = 24'hFFFFFF; w2[5] = 24'hFFFFFF; ex[5] = 8'hFF;
      w0[6] = 24'h000000; w1[6] = 24'h000000; w2[6] = 24'h00000F;
`ifdef KP_GAUSS_ROUND_EN
      ex[3] = 8'h02;
      ex[6] = 8'h01;
`else
      ex[3] = 8'h01;
      ex[6] = 8'h00;
`endif
      do_reset();
      for (int c = 0; c < 10; c++) begin
         if (c < 7) set_win(w0[c], w1[c], w2[c], 1'b1);
         else       set_win(24'h0, 24'h0, 24'h0, 1'b0);
         tick();
         if (c >= 2 && c < 9) begin
            n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL pat_valid idx=%0d got=%b exp=1", c - 2, o_valid); end
            n_cmp++; if (o_data !== ex[c-2]) begin n_fail++; $display("FAIL pat_data idx=%0d got=%h exp=%h", c - 2, o_data, ex[c-2]); end
         end else if (c == 9) begin
            n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL pat_tail_valid got=%b exp=0", o_valid); end
         end
      end
   endtask

   // Alternating valid with bubbles: 9 windows across a 4x2 frame, then the next frame's first pixel.
   task automatic test_bubbles_markers;
      int  n;
      logic ev;
      n = 0;
      do_reset();
      for (int c = 0; c < 22; c++) begin
         set_win(24'h404040, 24'h404040, 24'h404040, (c % 2 == 0) && (c < 18));
         tick();
         if (c >= 2) begin
            ev = ((c - 2) % 2 == 0) && ((c - 2) < 18);
            n_cmp++; if (o_valid !== ev) begin n_fail++; $display("FAIL bub_valid c=%0d got=%b exp=%b", c, o_valid, ev); end
            if (ev) begin
               n++;
               n_cmp++; if (o_data !== 8'h40) begin n_fail++; $display("FAIL bub_data n=%0d got=%h exp=40", n, o_data); end
               n_cmp++; if (o_sof !== (n == 1 || n == 9)) begin n_fail++; $display("FAIL bub_sof n=%0d got=%b", n, o_sof); end
               n_cmp++; if (o_eol !== (n == 4 || n == 8)) begin n_fail++; $display("FAIL bub_eol n=%0d got=%b", n, o_eol); end
               n_cmp++; if (o_eof !== (n == 8)) begin n_fail++; $display("FAIL bub_eof n=%0d got=%b", n, o_eof); end
            end else begin
               n_cmp++;
               if ({o_sof, o_eol, o_eof} !== 3'b000) begin
                  n_fail++; $display("FAIL bub_markers_idle c=%0d got=%b%b%b exp=000", c, o_sof, o_eol, o_eof);
               end
            end
         end
      end
      n_cmp++; if (n !== 9) begin n_fail++; $display("FAIL bub_count got=%0d exp=9", n); end
   endtask

   task automatic test_reset_inflight;
      do_reset();
      // Move the column counter off zero first.
      set_win(24'h0, 24'h008000, 24'h0, 1'b1);
      tick();
      tick();
      set_win(24'h0, 24'h0, 24'h0, 1'b0);
      for (int c = 0; c < 4; c++) tick();
      set_win(24'h0, 24'h008000, 24'h0, 1'b1);
      tick();
      tick();
      rstn = 1'b0;
      set_win(24'h0, 24'h0, 24'h0, 1'b0);
      tick();
      rstn = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_flight_valid c=%0d got=%b exp=0", c, o_valid); end
      end
      set_win(24'h0, 24'h008000, 24'h0, 1'b1);
      tick();
      set_win(24'h0, 24'h0, 24'h0, 1'b0);
      tick();
      tick();
      n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rst_next_valid got=%b exp=1", o_valid); end
      n_cmp++; if (o_data !== 8'h20) begin n_fail++; $display("FAIL rst_next_data got=%h exp=20", o_data); end
      n_cmp++; if (o_sof !== 1'b1) begin n_fail++; $display("FAIL rst_next_sof got=%b exp=1", o_sof); end
      n_cmp++; if (o_eol !== 1'b0) begin n_fail++; $display("FAIL rst_next_eol got=%b exp=0", o_eol); end
   endtask

   initial begin
      clk    = 1'b0;
      n_cmp  = 0;
      n_fail = 0;
      rstn   = 1'b0;
      set_win(24'h0, 24'h0, 24'h0, 1'b0);
      test_reset();
      test_back_to_back();
      test_kernel_patterns();
      test_bubbles_markers();
      test_reset_inflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
